// File: rtl/tt_analog_pkg.sv
// Shared types and constants for the analog front-end blocks: SAR states,
// default converter sizing and the ua[] pin assignment.
package tt_analog_pkg;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_CNT_W       = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Analog pin map on ua[5:0]
    localparam int unsigned UA_DAC_OUT   = 0;
    localparam int unsigned UA_VIN       = 1;
    localparam int unsigned UA_CMP_OUT   = 2;
    localparam int unsigned UA_SAMPLE_SW = 3;
    localparam int unsigned UA_VREF      = 4;
    localparam int unsigned UA_SPARE     = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_TRIAL,
        S_DECIDE,
        S_DONE
    } state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation sequencer: sample phase, then one trial/decide
// pair per bit MSB first, then a one-cycle done pulse with the new result.
module sar_adc_ctrl
    import tt_analog_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [CNT_W-1:0] sample_len,
    input  logic [CNT_W-1:0] settle_cycles,
    input  logic             cmp_in,
    output logic             sample_en,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // Wide enough for settle_cycles + SYNC_STAGES - 1 without wrapping
    localparam int unsigned DCNT_W = $clog2((1 << CNT_W) + SYNC_STAGES);

    state_e             state_q, state_d;
    logic [DCNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   settle_q, settle_d;

    logic               sample_en_q, sample_en_d;
    logic [WIDTH-1:0]   dac_code_q, dac_code_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               cmp_sync;
    logic [DCNT_W-1:0]  trial_load;
    logic [WIDTH-1:0]   bit_mask;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cmp_in),
        .q_o   (cmp_sync)
    );

    assign trial_load = DCNT_W'(settle_q) + DCNT_W'(SYNC_STAGES - 1);
    assign bit_mask   = WIDTH'(1) << idx_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath next values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        work_d   = work_q;
        settle_d = settle_q;

        case (state_q)
            // DONE accepts a held start directly so back-to-back runs do not lose a cycle
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d  = S_SAMPLE;
                    cnt_d    = DCNT_W'(sample_len);
                    idx_d    = IDX_W'(WIDTH - 1);
                    work_d   = '0;
                    settle_d = settle_cycles;
                end
            end
            S_SAMPLE: begin
                if (cnt_q == '0) begin
                    state_d = S_TRIAL;
                    cnt_d   = trial_load;
                end else begin
                    cnt_d = cnt_q - DCNT_W'(1);
                end
            end
            S_TRIAL: begin
                if (cnt_q == '0) begin
                    state_d = S_DECIDE;
                end else begin
                    cnt_d = cnt_q - DCNT_W'(1);
                end
            end
            S_DECIDE: begin
                if (cmp_sync) begin
                    work_d = work_q | bit_mask;
                end
                if (idx_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_TRIAL;
                    idx_d   = idx_q - IDX_W'(1);
                    cnt_d   = trial_load;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!ena) begin
            state_d = S_IDLE;
        end
    end

    // Registered outputs follow the state being entered
    always_comb begin
        sample_en_d = 1'b0;
        dac_code_d  = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        result_d    = result_q;

        case (state_d)
            S_SAMPLE: begin
                sample_en_d = 1'b1;
                busy_d      = 1'b1;
            end
            S_TRIAL, S_DECIDE: begin
                busy_d     = 1'b1;
                dac_code_d = work_d | (WIDTH'(1) << idx_d);
            end
            S_DONE: begin
                done_d     = 1'b1;
                dac_code_d = work_d;
                result_d   = work_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            work_q      <= '0;
            settle_q    <= '0;
            sample_en_q <= 1'b0;
            dac_code_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            work_q      <= work_d;
            settle_q    <= settle_d;
            sample_en_q <= sample_en_d;
            dac_code_q  <= dac_code_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
        end
    end

    assign sample_en = sample_en_q;
    assign dac_code  = dac_code_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Randomised bench for sar_adc_ctrl: an ideal comparator on vin and a
// binary-search reference model predict codes, trial order and timing.
module tb_sar_adc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [3:0] sample_len;
    logic [3:0] settle_cycles;
    logic       cmp_in;
    logic       sample_en;
    logic [7:0] dac_code;
    logic       busy;
    logic       done;
    logic [7:0] result;

    logic [7:0] vin;
    int         total = 0;
    int         bad   = 0;

    logic [7:0] trial_q[$];
    int         hold_q[$];
    logic [7:0] exp_trial_q[$];
    int         samp_cnt;

    sar_adc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .start         (start),
        .sample_len    (sample_len),
        .settle_cycles (settle_cycles),
        .cmp_in        (cmp_in),
        .sample_en     (sample_en),
        .dac_code      (dac_code),
        .busy          (busy),
        .done          (done),
        .result        (result)
    );

    always #5 clk = ~clk;

    assign cmp_in = (vin >= dac_code);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Binary search on an ideal comparator: list of trial codes and final code
    task automatic model(input logic [7:0] v, output logic [7:0] res);
        logic [7:0] code;
        logic [7:0] t;
        code = 8'h00;
        exp_trial_q.delete();
        for (int b = 7; b >= 0; b--) begin
            t = code | (8'd1 << b);
            exp_trial_q.push_back(t);
            if (v >= t) code = t;
        end
        res = code;
    endtask

    function automatic int exp_latency(input logic [3:0] sl, input logic [3:0] st);
        return (int'(sl) + 1) + 8 * (int'(st) + 2 + 1) + 1;
    endfunction

    // Start one conversion with a one-cycle start pulse and record what it does
    task automatic run_conv(input logic [7:0] v, input logic [3:0] sl, input logic [3:0] st,
                            output int lat);
        logic [7:0] prev;
        trial_q.delete();
        hold_q.delete();
        samp_cnt = 0;
        lat = 0;
        prev = 8'h00;
        vin = v;
        sample_len = sl;
        settle_cycles = st;
        start = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            tick();
            start = 1'b0;
            if (sample_en) samp_cnt++;
            if (busy && !sample_en) begin
                if (trial_q.size() == 0 || dac_code != prev) begin
                    trial_q.push_back(dac_code);
                    hold_q.push_back(1);
                    prev = dac_code;
                end else begin
                    hold_q[hold_q.size()-1] = hold_q[hold_q.size()-1] + 1;
                end
            end
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena = 1'b1;
        start = 1'b0;
        sample_len = 4'd0;
        settle_cycles = 4'd0;
        vin = 8'h00;
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (sample_en !== 1'b0) begin bad++; $display("FAIL reset_sample_en got=%b want=0", sample_en); end
        total++; if (dac_code !== 8'h00) begin bad++; $display("FAIL reset_dac got=%h want=00", dac_code); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h want=00", result); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        logic [7:0] exp_res;
        logic seq_ok;
        run_conv(8'hA5, 4'd2, 4'd3, lat);
        model(8'hA5, exp_res);
        total++; if (lat != 52) begin bad++; $display("FAIL basic_latency got=%0d want=52", lat); end
        total++; if (result !== exp_res) begin bad++; $display("FAIL basic_result got=%h want=%h", result, exp_res); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", busy); end
        total++; if (dac_code !== exp_res) begin bad++; $display("FAIL basic_dac_at_done got=%h want=%h", dac_code, exp_res); end
        total++; if (samp_cnt != 3) begin bad++; $display("FAIL basic_sample_cycles got=%0d want=3", samp_cnt); end
        seq_ok = (trial_q.size() == exp_trial_q.size());
        for (int i = 0; i < trial_q.size() && seq_ok; i++)
            if (trial_q[i] !== exp_trial_q[i] || hold_q[i] != 6) seq_ok = 1'b0;
        total++; if (!seq_ok) begin bad++; $display("FAIL basic_trials got=%p holds=%p want=%p hold=6", trial_q, hold_q, exp_trial_q); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse_width got=%b want=0", done); end
    endtask

    task automatic test_extremes();
        logic [7:0] vals[2];
        int lat;
        logic [7:0] exp_res;
        logic seq_ok;
        vals[0] = 8'h00;
        vals[1] = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            run_conv(vals[k], 4'd2, 4'd3, lat);
            model(vals[k], exp_res);
            total++; if (result !== exp_res) begin bad++; $display("FAIL extreme_result vin=%h got=%h want=%h", vals[k], result, exp_res); end
            total++; if (lat != 52) begin bad++; $display("FAIL extreme_latency vin=%h got=%0d want=52", vals[k], lat); end
            seq_ok = (trial_q.size() == exp_trial_q.size());
            for (int i = 0; i < trial_q.size() && seq_ok; i++)
                if (trial_q[i] !== exp_trial_q[i]) seq_ok = 1'b0;
            total++; if (!seq_ok) begin bad++; $display("FAIL extreme_trials vin=%h got=%p want=%p", vals[k], trial_q, exp_trial_q); end
            tick();
        end
    endtask

    task automatic test_random();
        int lat;
        logic [7:0] v;
        logic [3:0] sl, st;
        logic [7:0] exp_res;
        logic seq_ok;
        for (int n = 0; n < 10; n++) begin
            v  = 8'($urandom);
            sl = 4'($urandom);
            st = 4'($urandom);
            if (n == 0) begin sl = 4'hF; st = 4'hF; end
            if (n == 1) begin sl = 4'h0; st = 4'h0; end
            run_conv(v, sl, st, lat);
            model(v, exp_res);
            total++; if (result !== exp_res) begin bad++; $display("FAIL rand_result vin=%h got=%h want=%h", v, result, exp_res); end
            total++; if (lat != exp_latency(sl, st)) begin bad++; $display("FAIL rand_latency sl=%0d st=%0d got=%0d want=%0d", sl, st, lat, exp_latency(sl, st)); end
            total++; if (samp_cnt != int'(sl) + 1) begin bad++; $display("FAIL rand_sample_cycles got=%0d want=%0d", samp_cnt, int'(sl) + 1); end
            seq_ok = (trial_q.size() == exp_trial_q.size());
            for (int i = 0; i < trial_q.size() && seq_ok; i++)
                if (trial_q[i] !== exp_trial_q[i] || hold_q[i] != int'(st) + 3) seq_ok = 1'b0;
            total++; if (!seq_ok) begin bad++; $display("FAIL rand_trials vin=%h st=%0d got=%p holds=%p want=%p", v, st, trial_q, hold_q, exp_trial_q); end
            tick();
        end
    endtask

    task automatic test_start_while_busy();
        int ndone;
        int first;
        logic [7:0] v;
        v = 8'($urandom);
        vin = v;
        sample_len = 4'd2;
        settle_cycles = 4'd3;
        start = 1'b1;
        ndone = 0;
        first = 0;
        for (int c = 1; c <= 120; c++) begin
            tick();
            start = (c == 10);
            if (c == 12) begin
                sample_len = 4'd9;
                settle_cycles = 4'd9;
            end
            if (done) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        total++; if (ndone != 1) begin bad++; $display("FAIL busy_start_done_count got=%0d want=1", ndone); end
        total++; if (first != 52) begin bad++; $display("FAIL busy_start_latency got=%0d want=52", first); end
        total++; if (result !== v) begin bad++; $display("FAIL busy_start_result got=%h want=%h", result, v); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_idle got=%b want=0", busy); end
    endtask

    task automatic test_ena_abort();
        int lat;
        int ndone;
        run_conv(8'hA5, 4'd2, 4'd3, lat);
        total++; if (result !== 8'hA5) begin bad++; $display("FAIL abort_prior_result got=%h want=a5", result); end
        tick();
        vin = 8'h5A;
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            start = 1'b0;
        end
        ena = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (sample_en !== 1'b0) begin bad++; $display("FAIL abort_sample_en got=%b want=0", sample_en); end
        total++; if (dac_code !== 8'h00) begin bad++; $display("FAIL abort_dac got=%h want=00", dac_code); end
        total++; if (result !== 8'hA5) begin bad++; $display("FAIL abort_result got=%h want=a5", result); end
        ndone = (done === 1'b1) ? 1 : 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (c == 3) ena = 1'b1;
            if (done === 1'b1) ndone++;
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", ndone); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [7:0] exp_res;
        vin = 8'h77;
        sample_len = 4'd2;
        settle_cycles = 4'd3;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (dac_code !== 8'h00) begin bad++; $display("FAIL rstmid_dac got=%h want=00", dac_code); end
        total++; if (sample_en !== 1'b0) begin bad++; $display("FAIL rstmid_sample_en got=%b want=0", sample_en); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL rstmid_result got=%h want=00", result); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_conv(8'h3C, 4'd2, 4'd3, lat);
        model(8'h3C, exp_res);
        total++; if (result !== exp_res) begin bad++; $display("FAIL rstmid_fresh_result got=%h want=%h", result, exp_res); end
        total++; if (lat != 52) begin bad++; $display("FAIL rstmid_fresh_latency got=%0d want=52", lat); end
        tick();
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        logic [7:0] r1, r2, rmid;
        t1 = 0; t2 = 0; r1 = 8'h00; r2 = 8'h00; rmid = 8'h00;
        vin = 8'h10;
        sample_len = 4'd2;
        settle_cycles = 4'd3;
        start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (done) begin
                if (t1 == 0) begin
                    t1 = c;
                    r1 = result;
                    vin = 8'h20;
                end else begin
                    t2 = c;
                    r2 = result;
                    break;
                end
            end
            if (t1 != 0 && c == t1 + 1) start = 1'b0;
            if (t1 != 0 && c == t1 + 20) rmid = result;
        end
        total++; if (r1 !== 8'h10) begin bad++; $display("FAIL b2b_first_result got=%h want=10", r1); end
        total++; if (r2 !== 8'h20) begin bad++; $display("FAIL b2b_second_result got=%h want=20", r2); end
        total++; if (t2 - t1 != 52 || t1 == 0) begin bad++; $display("FAIL b2b_gap got=%0d want=52", t2 - t1); end
        total++; if (rmid !== 8'h10) begin bad++; $display("FAIL b2b_result_held got=%h want=10", rmid); end
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_no_third got=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_random();
        test_start_while_busy();
        test_ena_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
